xor_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer sharing one WIDTH-bit XOR datapath (WIDTH x xor_gate)

---
 rtl/xor_rr_arbiter_pkg.sv | 14 +
 rtl/xor_rr_arbiter_xor_gate.sv | 11 +
 rtl/xor_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_xor_rr_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/xor_rr_arbiter_pkg.sv
// Shared definitions for the round-robin XOR arbiter: FSM state
// encodings and default sizing constants.
package xor_rr_arbiter_pkg;

  localparam int N_REQ_DFLT = 4;
  localparam int WIDTH_DFLT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/xor_rr_arbiter_xor_gate.sv
// Single-bit XOR cell; WIDTH of these form the shared datapath.
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  // Bitwise XOR, no carry.
  assign y = a ^ b;

endmodule

// File: rtl/xor_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit XOR datapath among N_REQ
// requesters. One request is outstanding at a time; the result comes
// back tagged with the owning requester index.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | offering a grant to the next valid requester from ptr
// ST_EXEC | operands latched, XOR result being registered
// ST_RESP | result presented, waiting for resp_ready
module xor_rr_arbiter
  import xor_rr_arbiter_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DFLT,
  parameter  int WIDTH = WIDTH_DFLT,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [WIDTH-1:0]       resp_y,
  output logic                   busy
);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  ptr_nxt;
  logic             found;
  logic [N_REQ-1:0] grant;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] xor_y;
  logic             accept;

  // Round-robin pick: first valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_sel;
    found  = 1'b0;
    win_id = '0;
    grant  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_sel = ID_W'(idx);
      if (!found && req_valid[idx_sel]) begin
        found  = 1'b1;
        win_id = idx_sel;
      end
    end
    if (found) grant[win_id] = 1'b1;
  end

  // Winner's operands and the pointer value that follows it; wraps without touching unused indices.
  always_comb begin
    win_a   = req_a[int'(win_id)*WIDTH +: WIDTH];
    win_b   = req_b[int'(win_id)*WIDTH +: WIDTH];
    ptr_nxt = (int'(win_id) == N_REQ - 1) ? '0 : win_id + ID_W'(1);
  end

  assign accept = (state == ST_IDLE) && found;

  // Shared datapath: one XOR cell per operand bit, fed from the latched operands.
  for (genvar i = 0; i < WIDTH; i++) begin : g_xor
    xor_gate u_xor (
      .a (op_a[i]),
      .b (op_b[i]),
      .y (xor_y[i])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (found)      state_nxt = ST_EXEC;
      ST_EXEC:                 state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; grants are offered only in IDLE and never while in reset.
  always_comb begin
    req_ready  = (state == ST_IDLE && rst_n) ? grant : '0;
    resp_valid = (state == ST_RESP);
    busy       = (state != ST_IDLE);
  end

  // Operand/ID capture on acceptance, pointer advance, and result registration in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      resp_id <= '0;
      resp_y  <= '0;
    end else begin
      if (accept) begin
        op_a    <= win_a;
        op_b    <= win_b;
        resp_id <= win_id;
        ptr     <= ptr_nxt;
      end
      if (state == ST_EXEC) resp_y <= xor_y;
    end
  end

endmodule

// File: tb/tb_xor_rr_arbiter.sv
// Self-checking bench for xor_rr_arbiter: directed scenarios plus random
// traffic, checked each cycle against a transaction-level reference model.
module tb_xor_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_y;
  logic           busy;

  logic [N-1:0]   w1_valid;
  logic [N-1:0]   w1_ready;
  logic [N-1:0]   w1_a;
  logic [N-1:0]   w1_b;
  logic           w1_resp_valid;
  logic           w1_resp_ready;
  logic [1:0]     w1_resp_id;
  logic [0:0]     w1_resp_y;
  logic           w1_busy;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: which step of a transaction we are in and what it must return.
  int         m_ptr;
  int         m_phase;   // 0 = no transaction, 1 = accepted last cycle, 2 = result due
  int         m_id;
  logic [7:0] m_y;

  always #5 clk = ~clk;

  xor_rr_arbiter #(.N_REQ(N), .WIDTH(W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .busy       (busy)
  );

  xor_rr_arbiter #(.N_REQ(N), .WIDTH(1)) u_dut_w1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (w1_valid),
    .req_ready  (w1_ready),
    .req_a      (w1_a),
    .req_b      (w1_b),
    .resp_valid (w1_resp_valid),
    .resp_ready (w1_resp_ready),
    .resp_id    (w1_resp_id),
    .resp_y     (w1_resp_y),
    .busy       (w1_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One clock of stimulus starting at a falling edge: drive, check, advance model.
  task automatic step(input logic [N-1:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic rr);
    int         w;
    logic [N-1:0] eg;
    req_valid  = v;
    req_a      = a;
    req_b      = b;
    resp_ready = rr;
    #1;
    w  = (m_phase == 0) ? rr_pick(v, m_ptr) : -1;
    eg = (w >= 0) ? N'(1 << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("resp_valid", 32'(resp_valid), 32'(m_phase == 2));
    if (m_phase == 2) begin
      chk("resp_id", 32'(resp_id), 32'(m_id));
      chk("resp_y", 32'(resp_y), 32'(m_y));
    end
    @(posedge clk);
    if (m_phase == 0) begin
      if (w >= 0) begin
        m_id    = w;
        m_y     = a[w*8 +: 8] ^ b[w*8 +: 8];
        m_ptr   = (w + 1) % N;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (rr) begin
      m_phase = 0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 6 && m_phase != 0; k++) step('0, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [3:0] tt;
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    w1_valid = '0; w1_a = '0; w1_b = '0; w1_resp_ready = 1'b0;
    m_ptr = 0; m_phase = 0; m_id = 0; m_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_y", 32'(resp_y), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from requester 1.
    step(4'b0010, 32'h0000_A500, 32'h0000_3C00, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    chk("t1_resp_y", 32'(resp_y), 32'h99);
    chk("t1_resp_id", 32'(resp_id), 32'd1);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    // Requester 2 must now win over 1 since ptr has moved past 1.
    step(4'b0110, 32'h0, 32'h0, 1'b1);
    chk("t1_next_grant", 32'(resp_valid), 32'd0);
    drain();

    // Full contention with resp_ready high.
    for (int k = 0; k < 16; k++)
      step(4'b1111, $urandom, $urandom, 1'b1);
    drain();

    // Wrap: grant 2, then 0 and 2 from 4'b0101.
    step(4'b0100, 32'h0011_0000, 32'h0022_0000, 1'b1);
    drain();
    for (int k = 0; k < 6; k++) step(4'b0101, $urandom, $urandom, 1'b1);
    drain();

    // Backpressure in RESP.
    step(4'b1000, 32'h5A00_0000, 32'h0F00_0000, 1'b0);
    step(4'b1111, $urandom, $urandom, 1'b0);
    for (int k = 0; k < 5; k++) step(4'b1111, $urandom, $urandom, 1'b0);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    drain();

    // Operand change after acceptance.
    step(4'b0001, 32'h0000_00FF, 32'h0000_0000, 1'b1);
    step(4'b0001, 32'h0000_0000, 32'h0000_0000, 1'b1);
    chk("t5_resp_y", 32'(resp_y), 32'hFF);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    drain();

    // Random traffic.
    for (int k = 0; k < 400; k++)
      step(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 3) != 0));
    drain();

    // Reset while a result is pending.
    step(4'b0100, 32'h0077_0000, 32'h0011_0000, 1'b0);
    step(4'b0000, 32'h0, 32'h0, 1'b0);
    step(4'b0000, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_resp_valid", 32'(resp_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_resp_y", 32'(resp_y), 32'd0);
    chk("t6_resp_id", 32'(resp_id), 32'd0);
    m_ptr = 0; m_phase = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(4'b1000, 32'h1200_0000, 32'h3400_0000, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    chk("t6_after_id", 32'(resp_id), 32'd3);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    drain();
    // ptr was 0 after reset, so with 0 and 3 both valid, 3's grant advanced ptr to 0: 0 wins.
    step(4'b1001, 32'h0, 32'h0, 1'b1);
    drain();

    // WIDTH=1 truth table on requester 0.
    tt = 4'b0110;
    for (int p = 0; p < 4; p++) begin
      w1_valid = 4'b0001;
      w1_a = {3'b000, 1'(p >> 1)};
      w1_b = {3'b000, 1'(p & 1)};
      w1_resp_ready = 1'b1;
      #1;
      chk("w1_ready", 32'(w1_ready), 32'd1);
      @(negedge clk);
      w1_valid = '0;
      @(negedge clk);
      chk("w1_resp_valid", 32'(w1_resp_valid), 32'd1);
      chk("w1_resp_y", 32'(w1_resp_y), 32'(tt[p]));
      @(negedge clk);
      chk("w1_idle", 32'(w1_busy), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
